// File: rtl/intra_pred_8x8_if.sv
// Request/response bundle between the reference buffers, the 8x8 intra
// predictor and the residual stage. master = producer side, slave = predictor.
interface intra_pred_8x8_if #(parameter int PIX_W = 8);
  logic                 START;
  logic [1:0]           MODE;
  logic                 LEFT_AVAIL;
  logic                 TOP_AVAIL;
  logic [8*PIX_W-1:0]   REF_LEFT;
  logic [8*PIX_W-1:0]   REF_TOP;
  logic [8*PIX_W-1:0]   PRED_ROW;
  logic [2:0]           ROW_IDX;
  logic                 PRED_VALID;
  logic                 PRED_READY;
  logic                 BUSY;
  logic                 DONE;
  logic                 ERR;

  modport master (
    output START, MODE, LEFT_AVAIL, TOP_AVAIL, REF_LEFT, REF_TOP, PRED_READY,
    input  PRED_ROW, ROW_IDX, PRED_VALID, BUSY, DONE, ERR
  );
  modport slave (
    input  START, MODE, LEFT_AVAIL, TOP_AVAIL, REF_LEFT, REF_TOP, PRED_READY,
    output PRED_ROW, ROW_IDX, PRED_VALID, BUSY, DONE, ERR
  );
endinterface

// File: rtl/intra_pred_8x8.sv
// 8x8 intra predictor (vertical / horizontal / DC): snapshots references on
// START, accumulates neighbour sums over 8 cycles, then streams one row per handshake.
module intra_pred_8x8 #(
  parameter int PIX_W      = 8,
  parameter int DC_DEFAULT = 128
) (
  input logic             CLK,
  input logic             RST,
  intra_pred_8x8_if.slave io
);
  localparam int NUM_LANES = 8;
  localparam int SUM_W     = PIX_W + 3;
  localparam logic [1:0] M_VER = 2'd0, M_HOR = 2'd1, M_DC = 2'd2;

  typedef enum logic [1:0] {IDLE, CALC, EMIT, FIN} state_e;
  typedef logic [NUM_LANES-1:0][PIX_W-1:0] row_t;

  state_e            state_q, state_d;
  row_t              left_q, left_d, top_q, top_d, row_q, row_d;
  logic [1:0]        mode_q, mode_d;
  logic              lavail_q, lavail_d, tavail_q, tavail_d;
  logic [2:0]        cnt_q, cnt_d, row_idx_q, row_idx_d;
  logic [SUM_W-1:0]  sum_l_q, sum_l_d, sum_t_q, sum_t_d;
  logic [PIX_W-1:0]  dc_q, dc_d;
  logic              valid_q, valid_d, done_q, done_d, err_q, err_d;

  logic [SUM_W-1:0]  sum_l_nx, sum_t_nx, sum_l_rnd, sum_t_rnd;
  logic [SUM_W:0]    sum_both;
  logic [1:0]        eff_mode;
  logic              eff_err;
  logic [PIX_W-1:0]  dc_calc;

  function automatic row_t build_row(input logic [1:0] m, input logic [2:0] r,
                                     input logic [PIX_W-1:0] dc, input row_t l, input row_t t);
    row_t row;
    for (int i = 0; i < NUM_LANES; i++) begin
      case (m)
        M_VER:   row[i] = t[i];
        M_HOR:   row[i] = l[r];
        default: row[i] = dc;
      endcase
    end
    return row;
  endfunction

  // Sums including this cycle's lane, so the last CALC cycle sees final totals.
  always_comb begin
    sum_l_nx  = sum_l_q + SUM_W'(left_q[cnt_q]);
    sum_t_nx  = sum_t_q + SUM_W'(top_q[cnt_q]);
    sum_both  = {1'b0, sum_l_nx} + {1'b0, sum_t_nx} + (SUM_W+1)'(8);
    sum_l_rnd = sum_l_nx + SUM_W'(4);
    sum_t_rnd = sum_t_nx + SUM_W'(4);
    case ({lavail_q, tavail_q})
      2'b11:   dc_calc = PIX_W'(sum_both >> 4);
      2'b10:   dc_calc = PIX_W'(sum_l_rnd >> 3);
      2'b01:   dc_calc = PIX_W'(sum_t_rnd >> 3);
      default: dc_calc = PIX_W'(DC_DEFAULT);
    endcase
    eff_mode = mode_q;
    eff_err  = 1'b0;
    if ((mode_q == 2'd3) || (mode_q == M_VER && !tavail_q) || (mode_q == M_HOR && !lavail_q)) begin
      eff_mode = M_DC;
      eff_err  = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    left_d    = left_q;
    top_d     = top_q;
    mode_d    = mode_q;
    lavail_d  = lavail_q;
    tavail_d  = tavail_q;
    cnt_d     = cnt_q;
    sum_l_d   = sum_l_q;
    sum_t_d   = sum_t_q;
    dc_d      = dc_q;
    row_d     = row_q;
    row_idx_d = row_idx_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    err_d     = err_q;
    case (state_q)
      IDLE: if (io.START) begin
        left_d   = io.REF_LEFT;
        top_d    = io.REF_TOP;
        mode_d   = io.MODE;
        lavail_d = io.LEFT_AVAIL;
        tavail_d = io.TOP_AVAIL;
        err_d    = 1'b0;
        cnt_d    = '0;
        sum_l_d  = '0;
        sum_t_d  = '0;
        state_d  = CALC;
      end
      CALC: begin
        sum_l_d = sum_l_nx;
        sum_t_d = sum_t_nx;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          mode_d    = eff_mode;
          err_d     = eff_err;
          dc_d      = dc_calc;
          row_d     = build_row(eff_mode, 3'd0, dc_calc, left_q, top_q);
          row_idx_d = '0;
          valid_d   = 1'b1;
          state_d   = EMIT;
        end
      end
      EMIT: if (io.PRED_READY) begin
        if (row_idx_q == 3'd7) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          row_idx_d = row_idx_q + 3'd1;
          row_d     = build_row(mode_q, row_idx_q + 3'd1, dc_q, left_q, top_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      left_q    <= '0;
      top_q     <= '0;
      mode_q    <= '0;
      lavail_q  <= 1'b0;
      tavail_q  <= 1'b0;
      cnt_q     <= '0;
      sum_l_q   <= '0;
      sum_t_q   <= '0;
      dc_q      <= '0;
      row_q     <= '0;
      row_idx_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      left_q    <= left_d;
      top_q     <= top_d;
      mode_q    <= mode_d;
      lavail_q  <= lavail_d;
      tavail_q  <= tavail_d;
      cnt_q     <= cnt_d;
      sum_l_q   <= sum_l_d;
      sum_t_q   <= sum_t_d;
      dc_q      <= dc_d;
      row_q     <= row_d;
      row_idx_q <= row_idx_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign io.PRED_ROW   = row_q;
  assign io.ROW_IDX    = row_idx_q;
  assign io.PRED_VALID = valid_q;
  assign io.BUSY       = (state_q != IDLE);
  assign io.DONE       = done_q;
  assign io.ERR        = err_q;
endmodule

// File: tb/tb_intra_pred_8x8.sv
// Randomized + directed bench for intra_pred_8x8 against a per-pixel reference model.
module tb_intra_pred_8x8;
  logic CLK = 1'b0;
  logic RST;
  intra_pred_8x8_if #(.PIX_W(8)) io();
  intra_pred_8x8 #(.PIX_W(8), .DC_DEFAULT(128)) dut (.CLK(CLK), .RST(RST), .io(io));

  always #5 CLK = ~CLK;

  int          n_chk = 0;
  int          n_err = 0;
  int          lv[8];
  int          tv[8];
  logic [63:0] exp_rows[8];
  logic        exp_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Whole-block expectation from the prediction rules.
  task automatic model(input int mode, input int la, input int ta);
    int sl, st, dc, m, pix;
    sl = 0; st = 0;
    for (int i = 0; i < 8; i++) begin sl += lv[i]; st += tv[i]; end
    m = mode;
    exp_err = 1'b0;
    if (mode == 3 || (mode == 0 && ta == 0) || (mode == 1 && la == 0)) begin
      m = 2; exp_err = 1'b1;
    end
    if (la != 0 && ta != 0) dc = (sl + st + 8) / 16;
    else if (la != 0)       dc = (sl + 4) / 8;
    else if (ta != 0)       dc = (st + 4) / 8;
    else                    dc = 128;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++) begin
        pix = (m == 0) ? tv[i] : (m == 1) ? lv[r] : dc;
        exp_rows[r][8*i +: 8] = pix[7:0];
      end
    end
  endtask

  task automatic drive_refs();
    for (int i = 0; i < 8; i++) begin
      io.REF_LEFT[8*i +: 8] = lv[i][7:0];
      io.REF_TOP[8*i +: 8]  = tv[i][7:0];
    end
  endtask

  // pat: 0 = READY high, 1 = toggle 1/0, 2 = random. poke: START pulse during CALC.
  task automatic run_block(input int mode, input int la, input int ta, input int pat, input bit poke);
    int lat, rows, cyc;
    bit tog, rdy;
    model(mode, la, ta);
    io.START = 1'b1; io.MODE = mode[1:0]; io.LEFT_AVAIL = la[0]; io.TOP_AVAIL = ta[0];
    drive_refs();
    step(); lat = 1;
    io.START = 1'b0;
    io.REF_LEFT = {$urandom(), $urandom()};
    io.REF_TOP  = {$urandom(), $urandom()};
    io.MODE = 2'($urandom_range(0, 3));
    io.LEFT_AVAIL = 1'($urandom_range(0, 1));
    io.TOP_AVAIL  = 1'($urandom_range(0, 1));
    chk("busy_calc", io.BUSY, 1);
    chk("err_cleared", io.ERR, 0);
    if (poke) begin
      io.START = 1'b1; step(); lat++; io.START = 1'b0;
    end
    while (!io.PRED_VALID && lat < 30) begin step(); lat++; end
    chk("first_valid_lat", lat, 9);
    rows = 0; cyc = 0; tog = 1'b1;
    while (rows < 8 && cyc < 200) begin
      rdy = (pat == 0) ? 1'b1 : (pat == 1) ? tog : 1'($urandom_range(0, 1));
      tog = !tog;
      io.PRED_READY = rdy;
      chk("valid", io.PRED_VALID, 1);
      chk("row_idx", io.ROW_IDX, rows);
      chk("row", io.PRED_ROW, exp_rows[rows]);
      chk("done_early", io.DONE, 0);
      if (rdy) rows++;
      step(); lat++; cyc++;
    end
    if (rows != 8) chk("rows_timeout", rows, 8);
    io.PRED_READY = 1'b0;
    if (pat == 0) chk("done_lat", lat, 17);
    chk("done", io.DONE, 1);
    chk("valid_drop", io.PRED_VALID, 0);
    chk("err", io.ERR, exp_err);
    chk("busy_fin", io.BUSY, 1);
    step();
    chk("done_pulse", io.DONE, 0);
    chk("idle", io.BUSY, 0);
    chk("err_hold", io.ERR, exp_err);
  endtask

  task automatic rand_refs();
    for (int i = 0; i < 8; i++) begin
      lv[i] = $urandom_range(0, 255);
      tv[i] = $urandom_range(0, 255);
    end
  endtask

  initial begin
    int n, seen_done;
    RST = 1'b1;
    io.START = 1'b0; io.MODE = '0; io.LEFT_AVAIL = 1'b0; io.TOP_AVAIL = 1'b0;
    io.REF_LEFT = '0; io.REF_TOP = '0; io.PRED_READY = 1'b0;
    step(); step();
    chk("rst_row", io.PRED_ROW, 0);
    chk("rst_idx", io.ROW_IDX, 0);
    chk("rst_valid", io.PRED_VALID, 0);
    chk("rst_busy", io.BUSY, 0);
    chk("rst_done", io.DONE, 0);
    chk("rst_err", io.ERR, 0);
    RST = 1'b0;
    step();

    // vertical, top = 10..80
    rand_refs();
    for (int i = 0; i < 8; i++) tv[i] = 10 * (i + 1);
    run_block(0, 1, 1, 0, 1'b0);
    // horizontal, left = 1..8, READY toggling
    rand_refs();
    for (int i = 0; i < 8; i++) lv[i] = i + 1;
    run_block(1, 1, 1, 1, 1'b0);
    // DC both, extreme sums
    for (int i = 0; i < 8; i++) begin lv[i] = 255; tv[i] = 0; end
    run_block(2, 1, 1, 0, 1'b0);
    // DC left only
    rand_refs();
    for (int i = 0; i < 8; i++) lv[i] = (i < 4) ? 3 : 4;
    run_block(2, 1, 0, 0, 1'b0);
    // DC neither
    rand_refs();
    run_block(2, 0, 0, 2, 1'b0);
    // vertical without top -> DC of left
    rand_refs();
    for (int i = 0; i < 8; i++) lv[i] = 100;
    run_block(0, 1, 0, 0, 1'b0);
    // reserved mode, nothing available
    rand_refs();
    run_block(3, 0, 0, 0, 1'b0);
    // START during CALC ignored
    rand_refs();
    run_block(1, 1, 1, 0, 1'b1);

    for (int k = 0; k < 12; k++) begin
      rand_refs();
      run_block($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // reset in the middle of EMIT
    rand_refs();
    io.START = 1'b1; io.MODE = 2'd1; io.LEFT_AVAIL = 1'b1; io.TOP_AVAIL = 1'b1;
    drive_refs();
    step();
    io.START = 1'b0; io.PRED_READY = 1'b1;
    n = 0;
    while (!(io.PRED_VALID && io.ROW_IDX == 3'd3) && n < 40) begin step(); n++; end
    chk("rst_reach_row3", io.ROW_IDX, 3);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("mid_rst_valid", io.PRED_VALID, 0);
    chk("mid_rst_busy", io.BUSY, 0);
    chk("mid_rst_done", io.DONE, 0);
    chk("mid_rst_idx", io.ROW_IDX, 0);
    seen_done = 0;
    for (int c = 0; c < 20; c++) begin
      if (io.DONE || io.PRED_VALID || io.BUSY) seen_done++;
      step();
    end
    chk("mid_rst_quiet", seen_done, 0);
    io.PRED_READY = 1'b0;

    rand_refs();
    run_block(0, 1, 1, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
